// File: rtl/psi_input_packer_if.sv
// -----------------------------------------------------------------------------
// psi_input_packer_if
// Groups the element stream coming from upstream and the packed frame going to
// the psi core into one bundle.
//   in_valid  : upstream element valid
//   in_ready  : packer can accept an element
//   in_data   : element value (W bits, unsigned)
//   in_last   : final element of the current party's array
//   p_input   : packed frame, element j of party i at [(i*K+j)*W +: W]
//   p_valid   : p_input holds a complete frame
//   p_ack     : consumer has taken the frame
//   order_err : sticky, a frame contained a non-ascending element
//   len_err   : sticky, in_last was misplaced in a frame
// The slave modport is the packer's view; master is the producer/consumer side.
// -----------------------------------------------------------------------------
interface psi_input_packer_if #(
   parameter int W = 16,
   parameter int K = 16,
   parameter int N = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     in_data;
   logic             in_last;
   logic [W*K*N-1:0] p_input;
   logic             p_valid;
   logic             p_ack;
   logic             order_err;
   logic             len_err;

   modport slave (
      input  in_valid,
      input  in_data,
      input  in_last,
      input  p_ack,
      output in_ready,
      output p_input,
      output p_valid,
      output order_err,
      output len_err
   );

   modport master (
      output in_valid,
      output in_data,
      output in_last,
      output p_ack,
      input  in_ready,
      input  p_input,
      input  p_valid,
      input  order_err,
      input  len_err
   );
endinterface

// File: rtl/psi_input_packer.sv
// -----------------------------------------------------------------------------
// psi_input_packer
// Collects N party arrays of K elements each (party-major order) from a
// valid/ready stream and presents them as one flat bus to the psi core.
// While the frame is loading the packer checks that every party array is
// strictly ascending and that in_last lines up with the last element of each
// party; both problems are reported as sticky flags alongside p_valid.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : psi_input_packer_if.slave (stream in, frame out, error flags)
// -----------------------------------------------------------------------------
module psi_input_packer #(
   parameter int W = 16,
   parameter int K = 16,
   parameter int N = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   psi_input_packer_if.slave    bus
);

   localparam int EW = (K > 1) ? $clog2(K) : 1;
   localparam int PW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic {
      LOAD,
      FULL
   } state_t;

   state_t           state_q, state_d;
   logic [EW-1:0]    elemIdx_q, elemIdx_d;
   logic [PW-1:0]    partyIdx_q, partyIdx_d;
   logic [W-1:0]     prevData_q, prevData_d;
   logic [W*K*N-1:0] pInput_q, pInput_d;
   logic             orderErr_q, orderErr_d;
   logic             lenErr_q, lenErr_d;

   logic             xfer;
   logic             lastElem;
   logic             lastParty;
   logic             ackFull;
   int               slotBase;

   // A transfer only happens while loading; the frame is released by p_ack
   // only once it is full, so an ack that arrives during LOAD does nothing.
   assign xfer      = bus.in_valid && (state_q == LOAD);
   assign ackFull   = bus.p_ack && (state_q == FULL);
   assign lastElem  = (elemIdx_q == EW'(K - 1));
   assign lastParty = (partyIdx_q == PW'(N - 1));
   assign slotBase  = (int'(partyIdx_q) * K + int'(elemIdx_q)) * W;

   // State register: the only place the FSM state changes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= LOAD;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: the last element of the last party fills the frame,
   // and the consumer's ack reopens the packer for the next frame.
   always_comb begin
      state_d = state_q;
      case (state_q)
         LOAD: begin
            if (xfer && lastElem && lastParty) begin
               state_d = FULL;
            end
         end
         FULL: begin
            if (bus.p_ack) begin
               state_d = LOAD;
            end
         end
         default: state_d = LOAD;
      endcase
   end

   // Output decode: handshake outputs depend on the state register only, so
   // in_ready never has a combinational path from in_valid or p_ack.
   always_comb begin
      bus.in_ready = (state_q == LOAD);
      bus.p_valid  = (state_q == FULL);
   end

   // Datapath next-state: store the element into its slot, advance the
   // counters and accumulate the error flags.  Counters never wrap early on a
   // stray in_last; the frame is always exactly K*N transfers long.  Element
   // 0 of a party is not compared against the previous party's last element.
   always_comb begin
      elemIdx_d  = elemIdx_q;
      partyIdx_d = partyIdx_q;
      prevData_d = prevData_q;
      pInput_d   = pInput_q;
      orderErr_d = orderErr_q;
      lenErr_d   = lenErr_q;
      if (ackFull) begin
         elemIdx_d  = '0;
         partyIdx_d = '0;
         orderErr_d = 1'b0;
         lenErr_d   = 1'b0;
      end else if (xfer) begin
         pInput_d[slotBase +: W] = bus.in_data;
         prevData_d = bus.in_data;
         if (lastElem) begin
            elemIdx_d  = '0;
            partyIdx_d = partyIdx_q + PW'(1);
         end else begin
            elemIdx_d = elemIdx_q + EW'(1);
         end
         if ((elemIdx_q != '0) && (bus.in_data <= prevData_q)) begin
            orderErr_d = 1'b1;
         end
         if (bus.in_last != lastElem) begin
            lenErr_d = 1'b1;
         end
      end
   end

   // Datapath registers: reset clears the frame, counters and flags at once,
   // discarding any partial or unacknowledged frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         elemIdx_q  <= '0;
         partyIdx_q <= '0;
         prevData_q <= '0;
         pInput_q   <= '0;
         orderErr_q <= 1'b0;
         lenErr_q   <= 1'b0;
      end else begin
         elemIdx_q  <= elemIdx_d;
         partyIdx_q <= partyIdx_d;
         prevData_q <= prevData_d;
         pInput_q   <= pInput_d;
         orderErr_q <= orderErr_d;
         lenErr_q   <= lenErr_d;
      end
   end

   assign bus.p_input   = pInput_q;
   assign bus.order_err = orderErr_q;
   assign bus.len_err   = lenErr_q;

endmodule

// File: tb/tb_psi_input_packer.sv
// -----------------------------------------------------------------------------
// tb_psi_input_packer
// Drives frames of 64 elements (W=16, K=16, N=4) into psi_input_packer and
// compares the packed frame and error flags with a frame model built from the
// element list: element t of the stream belongs in slot t, the ordering flag
// is set if any non-first element of a party is not above its predecessor,
// and the length flag is set if any in_last differs from "t is a party end".
// -----------------------------------------------------------------------------
module tb_psi_input_packer;

   localparam int W  = 16;
   localparam int K  = 16;
   localparam int N  = 4;
   localparam int NE = K * N;

   typedef struct {
      string       name;
      int          modSlot;
      logic [15:0] modVal;
      int          lastOnSlot;
      int          lastOffSlot;
      bit          expOrder;
      bit          expLen;
   } vector_t;

   logic clk;
   logic rst_n;

   psi_input_packer_if #(.W(W), .K(K), .N(N)) bus();

   psi_input_packer #(.W(W), .K(K), .N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int          vecCount;
   int          missCount;
   int          riseCount;
   logic        pvPrev;
   logic [15:0] stimData [NE];
   logic        stimLast [NE];
   vector_t     vectors [6];

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Counts rising edges of p_valid, sampled on the falling clock edge.
   initial begin
      riseCount = 0;
      pvPrev    = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.p_valid === 1'b1 && pvPrev !== 1'b1) riseCount++;
         pvPrev = bus.p_valid;
      end
   end

   // One comparison: counts it and reports a miscompare with both values.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      vecCount++;
      if (actual !== expected) begin
         missCount++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
      end
   endtask

   // Reference frame image: stream element t goes to slot t.
   function automatic logic [W*K*N-1:0] modelImage();
      logic [W*K*N-1:0] img;
      img = '0;
      for (int t = 0; t < NE; t++) img[t*W +: W] = stimData[t];
      return img;
   endfunction

   function automatic bit modelOrderErr();
      bit e;
      e = 1'b0;
      for (int t = 0; t < NE; t++)
         if ((t % K) != 0 && stimData[t] <= stimData[t-1]) e = 1'b1;
      return e;
   endfunction

   function automatic bit modelLenErr();
      bit e;
      e = 1'b0;
      for (int t = 0; t < NE; t++)
         if (stimLast[t] != ((t % K) == K - 1)) e = 1'b1;
      return e;
   endfunction

   // Stream with party i element j = 100*i+j and correctly placed in_last.
   task automatic buildBase();
      for (int t = 0; t < NE; t++) begin
         stimData[t] = 16'((t / K) * 100 + (t % K));
         stimLast[t] = ((t % K) == K - 1);
      end
   endtask

   task automatic buildRamp();
      for (int t = 0; t < NE; t++) begin
         stimData[t] = 16'(t + 1);
         stimLast[t] = ((t % K) == K - 1);
      end
   endtask

   // Mostly ascending random data with occasional drops and misplaced lasts.
   task automatic buildRandom();
      for (int t = 0; t < NE; t++) begin
         if ((t % K) == 0) stimData[t] = 16'($urandom_range(0, 300));
         else if ($urandom_range(0, 9) < 8) stimData[t] = stimData[t-1] + 16'($urandom_range(1, 60));
         else stimData[t] = 16'($urandom_range(0, 65535));
         stimLast[t] = ((t % K) == K - 1);
         if ($urandom_range(0, 49) == 0) stimLast[t] = ~stimLast[t];
      end
   endtask

   // Sends stimData[0..count-1]; optional random idle cycles (with junk data
   // and in_last) and an optional p_ack pulse while loading before element
   // ackAt.  After a full frame, p_valid must rise exactly one cycle after
   // the last transfer.  Called and returns on a falling clock edge.
   task automatic applyStimulus(input int count, input bit gaps, input int ackAt);
      int budget;
      int g;
      for (int t = 0; t < count; t++) begin
         if (t == ackAt) begin
            bus.in_valid = 1'b0;
            bus.p_ack    = 1'b1;
            @(negedge clk);
            @(negedge clk);
            bus.p_ack    = 1'b0;
         end
         g = 0;
         while (gaps && $urandom_range(0, 1) == 1 && g < 8) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 16'($urandom);
            bus.in_last  = 1'($urandom);
            @(negedge clk);
            g++;
         end
         bus.in_valid = 1'b1;
         bus.in_data  = stimData[t];
         bus.in_last  = stimLast[t];
         budget = 50;
         while (bus.in_ready !== 1'b1 && budget > 0) begin
            @(negedge clk);
            budget--;
         end
         if (bus.in_ready !== 1'b1) begin
            checkOutput($sformatf("ready_timeout_t%0d", t), 32'(bus.in_ready), 32'd1);
            break;
         end
         if (t == NE - 1) checkOutput("pvalid_before_last", 32'(bus.p_valid), 32'd0);
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      if (count == NE) checkOutput("pvalid_latency", 32'(bus.p_valid), 32'd1);
   endtask

   // Compares every slot of p_input against the model image.
   task automatic checkFrame(input string tag);
      logic [W*K*N-1:0] img;
      img = modelImage();
      for (int t = 0; t < NE; t++)
         checkOutput($sformatf("%s_slot%0d", tag, t),
                     32'(bus.p_input[t*W +: W]), 32'(img[t*W +: W]));
   endtask

   // Acknowledges a full frame; one cycle later the packer is loading again
   // with both flags cleared.
   task automatic ackFrame(input string tag);
      bus.p_ack = 1'b1;
      @(negedge clk);
      bus.p_ack = 1'b0;
      checkOutput({tag, "_ack_ready"}, 32'(bus.in_ready), 32'd1);
      checkOutput({tag, "_ack_pvalid"}, 32'(bus.p_valid), 32'd0);
      checkOutput({tag, "_ack_order"}, 32'(bus.order_err), 32'd0);
      checkOutput({tag, "_ack_len"}, 32'(bus.len_err), 32'd0);
   endtask

   // Asserts reset between clock edges and checks the outputs are cleared
   // without waiting for a clock, then releases on a falling edge.
   task automatic applyReset(input string tag);
      #2 rst_n = 1'b0;
      #1;
      checkOutput({tag, "_rst_ready"}, 32'(bus.in_ready), 32'd1);
      checkOutput({tag, "_rst_pvalid"}, 32'(bus.p_valid), 32'd0);
      checkOutput({tag, "_rst_pinput_zero"}, 32'(bus.p_input == '0), 32'd1);
      checkOutput({tag, "_rst_order"}, 32'(bus.order_err), 32'd0);
      checkOutput({tag, "_rst_len"}, 32'(bus.len_err), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      int rises0;
      vecCount  = 0;
      missCount = 0;
      rst_n        = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.in_last  = 1'b0;
      bus.p_ack    = 1'b0;

      vectors[0] = '{"clean",        -1, 16'd0, -1, -1, 1'b0, 1'b0};
      vectors[1] = '{"p2e5_zero",    37, 16'd0, -1, -1, 1'b1, 1'b0};
      vectors[2] = '{"early_last",   -1, 16'd0,  7, -1, 1'b0, 1'b1};
      vectors[3] = '{"missing_last", -1, 16'd0, -1, 63, 1'b0, 1'b1};
      vectors[4] = '{"party_drop",   16, 16'd0, -1, -1, 1'b0, 1'b0};
      vectors[5] = '{"equal_elem",    3, 16'd2, -1, -1, 1'b1, 1'b0};

      @(negedge clk);
      applyReset("init");

      // Table-driven frames, each acknowledged before the next one.
      for (int v = 0; v < 6; v++) begin
         buildBase();
         if (vectors[v].modSlot >= 0) stimData[vectors[v].modSlot] = vectors[v].modVal;
         if (vectors[v].lastOnSlot >= 0) stimLast[vectors[v].lastOnSlot] = 1'b1;
         if (vectors[v].lastOffSlot >= 0) stimLast[vectors[v].lastOffSlot] = 1'b0;
         applyStimulus(NE, 1'b0, -1);
         checkFrame(vectors[v].name);
         checkOutput({vectors[v].name, "_order"}, 32'(bus.order_err), 32'(vectors[v].expOrder));
         checkOutput({vectors[v].name, "_len"}, 32'(bus.len_err), 32'(vectors[v].expLen));
         ackFrame(vectors[v].name);
      end

      // p_ack while loading must not restart the frame.
      buildRamp();
      applyStimulus(NE, 1'b0, 10);
      checkFrame("ack_in_load");
      ackFrame("ack_in_load");

      // Full frame held 20 cycles with in_valid asserted and no ack.
      buildBase();
      applyStimulus(NE, 1'b0, -1);
      bus.in_valid = 1'b1;
      for (int c = 0; c < 20; c++) begin
         bus.in_data = 16'($urandom);
         bus.in_last = 1'($urandom);
         @(negedge clk);
         checkOutput($sformatf("hold_ready_c%0d", c), 32'(bus.in_ready), 32'd0);
         checkOutput($sformatf("hold_pvalid_c%0d", c), 32'(bus.p_valid), 32'd1);
         checkOutput($sformatf("hold_stable_c%0d", c), 32'(bus.p_input == modelImage()), 32'd1);
      end
      bus.in_valid = 1'b0;
      ackFrame("hold");

      // Reset after 30 transfers (with an ordering error already flagged),
      // then a clean frame must pack from slot 0.
      buildBase();
      stimData[3] = 16'd0;
      applyStimulus(30, 1'b0, -1);
      checkOutput("midreset_order_pre", 32'(bus.order_err), 32'd1);
      applyReset("midframe");
      buildRamp();
      applyStimulus(NE, 1'b0, -1);
      checkFrame("after_midreset");

      // Reset while full drops the frame without an ack.
      applyReset("full");
      checkOutput("full_reset_ready", 32'(bus.in_ready), 32'd1);

      // Ramp frames with random idle cycles: same image, one p_valid rise each.
      rises0 = riseCount;
      for (int f = 0; f < 3; f++) begin
         buildRamp();
         applyStimulus(NE, 1'b1, -1);
         checkFrame($sformatf("gap%0d", f));
         checkOutput($sformatf("gap%0d_order", f), 32'(bus.order_err), 32'd0);
         ackFrame($sformatf("gap%0d", f));
      end
      checkOutput("gap_pvalid_rises", 32'(riseCount - rises0), 32'd3);

      // Random frames against the rule-based model.
      for (int f = 0; f < 4; f++) begin
         buildRandom();
         applyStimulus(NE, 1'b1, -1);
         checkFrame($sformatf("rnd%0d", f));
         checkOutput($sformatf("rnd%0d_order", f), 32'(bus.order_err), 32'(modelOrderErr()));
         checkOutput($sformatf("rnd%0d_len", f), 32'(bus.len_err), 32'(modelLenErr()));
         ackFrame($sformatf("rnd%0d", f));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule

// File: doc/psi_input_packer.md
PSI_INPUT_PACKER -- requirements
Module: psi_input_packer

Interface
REQ-001 Parameter W, default 16: bit width of each set element.
REQ-002 Parameter K, default 16: elements per party array; SHALL be even.
REQ-003 Parameter N, default 4: number of parties; SHALL be a power of 2, at least 2.
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1: reset, asynchronous, active-low.
REQ-006 in_valid  input  1: upstream element valid.
REQ-007 in_ready  output  1: packer can accept an element.
REQ-008 in_data  input  W: element value, unsigned.
REQ-009 in_last  input  1: marks the final element of the current party's array.
REQ-010 p_input  output  W*K*N: packed array bus for the psi core.
REQ-011 p_valid  output  1: p_input holds a complete frame.
REQ-012 p_ack  input  1: consumer has taken the frame.
REQ-013 order_err  output  1: sticky flag; a frame contained a non-ascending element.
REQ-014 len_err  output  1: sticky flag; in_last was misplaced in a frame.

Function
REQ-015 Transfer SHALL occur on any cycle with in_valid=1 and in_ready=1.
REQ-016 Element order SHALL be party-major: party 0 elements 0..K-1, then party 1, up to party N-1.
REQ-017 Element j of party i SHALL be written to p_input[(i*K+j)*W +: W].
REQ-018 Two states SHALL exist: LOAD (in_ready=1, p_valid=0) and FULL (in_ready=0, p_valid=1).
REQ-019 Counters SHALL be elem_idx, 0..K-1, and party_idx, 0..N-1.
  - On each transfer, elem_idx SHALL increment.
  - When elem_idx is K-1, elem_idx SHALL wrap to 0 and party_idx SHALL increment.
REQ-020 A transfer at elem_idx=K-1 and party_idx=N-1 SHALL move LOAD->FULL; p_valid SHALL be 1 in the next cycle (latency 1).
REQ-021 In FULL, p_ack=1 SHALL return the block to LOAD in the next cycle, with:
  - both counters 0;
  - order_err and len_err cleared;
  - p_input retained, overwritten slot by slot as the next frame loads.
REQ-022 p_ack in LOAD SHALL be ignored.
REQ-023 In FULL, p_valid SHALL stay 1 and p_input SHALL stay stable until p_ack.
REQ-024 Ordering rule: within a party, each element with elem_idx>0 SHALL be strictly greater than the previous element (unsigned compare).
  - A violation SHALL set order_err.
  - The element SHALL still be stored.
  - Element 0 of each party SHALL NOT be compared against the previous party's last element.
REQ-025 in_last=1 at elem_idx != K-1 SHALL set len_err; counters SHALL advance normally (no early wrap).
REQ-026 in_last=0 at elem_idx=K-1 SHALL also set len_err.
REQ-027 in_last SHALL be ignored when no transfer occurs.
REQ-028 order_err and len_err SHALL hold through FULL until p_ack, so the consumer can sample them with p_valid.
REQ-029 in_ready SHALL be a registered function of state only; it SHALL NOT depend combinationally on in_valid or p_ack.
REQ-030 in_data SHALL be ignored when no transfer occurs.

Reset
REQ-031 rst_n=0 SHALL immediately and asynchronously force the following, regardless of clk:
  - state LOAD, in_ready=1, p_valid=0;
  - p_input all zeros;
  - both counters 0;
  - order_err=0, len_err=0.
REQ-032 Reset during LOAD mid-frame SHALL discard the partial frame; the first transfer after release SHALL be stored as party 0, element 0.
REQ-033 Reset during FULL SHALL drop the frame without requiring p_ack.

Verification
REQ-034 W=16,K=16,N=4: stream 64 transfers with party i element j = 100*i+j, in_last at each j=15.
  - Required: p_valid=1 exactly one cycle after the 64th transfer.
  - Required: p_input[(i*16+j)*16 +: 16] = 100*i+j for all i, j.
  - Required: order_err=0, len_err=0.
REQ-035 Same stream with party 2 element 5 = 0.
  - Required: order_err=1 with p_valid, and 0 stored in that slot.
  - p_ack, then a clean frame -> order_err=0.
REQ-036 Hold p_ack=0 for 20 cycles in FULL while driving in_valid=1.
  - Required: in_ready=0, no p_input change.
  - p_ack=1 -> in_ready=1 next cycle.
REQ-037 in_last asserted at party 0 element 7.
  - Required: len_err=1; the frame still completes after exactly 64 transfers.
REQ-038 Assert rst_n=0 after 30 transfers, then release and send a full 64-element frame.
  - Required: outputs zeroed immediately at assertion.
  - Required: the new frame packs from slot 0 with p_valid after transfer 64.
REQ-039 Random in_valid gaps (50% duty) with a repeated 1..64 ramp.
  - Required: identical p_input to the gap-free run.
  - Required: exactly one p_valid rise per frame.
